// File: rtl/key_mode_sel.sv
// key_mode_sel
//   Push-button front end for the DA output multiplexer's `key` select.
//   It takes two asynchronous active-low buttons (UP/DOWN) and passes each one
//   through a 2-FF synchroniser, a debouncer and a press FSM. The resulting
//   steps move a 3-bit wrap-around mode register up or down.
//
//   Optional feature macro: KEY_AUTO_REPEAT_EN
//     defined   : hold-to-repeat. The first extra step comes REPEAT_DELAY cycles
//                 after the debounced press, then one step every REPEAT_PERIOD cycles.
//     undefined : exactly one step per debounced press. No repeat counters are built.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed to accept a level change (>= 2)
//   REPEAT_DELAY    : hold cycles before the first auto-repeat step
//   REPEAT_PERIOD   : cycles between later auto-repeat steps
//   INIT_MODE       : mode value loaded at reset
//
// Ports
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   btn_up_n  : UP button, async, 0 = pressed
//   btn_dn_n  : DOWN button, async, 0 = pressed
//   mode      : registered 3-bit select code
//   mode_chg  : one-cycle pulse in the first cycle mode shows a new value
//   btn_state : debounced pressed flags {up, dn}, 1 = pressed

module key_mode_sel #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter logic [2:0]  INIT_MODE       = 3'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_n,
  input  logic       btn_dn_n,
  output logic [2:0] mode,
  output logic       mode_chg,
  output logic [1:0] btn_state
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;

  // Index 1 is UP and index 0 is DOWN, which matches the btn_state ordering.
  logic [1:0] pin_n;
  logic [1:0] pressed;
  logic [1:0] step;

  assign pin_n     = {btn_up_n, btn_dn_n};
  assign btn_state = pressed;

`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam int HOLD_W = (REPEAT_DELAY > 2) ? $clog2(REPEAT_DELAY) : 1;
  localparam int PER_W  = (REPEAT_PERIOD > 2) ? $clog2(REPEAT_PERIOD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(REPEAT_PERIOD - 1);

  // When both buttons are held, repeats are frozen. Otherwise one button
  // would keep stepping while the other is only resting on its press.
  logic both_pressed;
  assign both_pressed = &pressed;
`else
  // The repeat timing parameters stay on the interface so that both builds
  // share one instantiation. In this build they have no effect.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic             sync1;
    logic             sync2;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_pressed;
    logic [1:0]       state;

    // The synchroniser resets to 1 (released). A button held through reset
    // therefore looks like a fresh press and must debounce again.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= pin_n[i];
        sync2 <= sync1;
      end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive samples
    // that disagree with the current level. Any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        deb_cnt     <= '0;
        deb_pressed <= 1'b0;
      end else if (~sync2 != deb_pressed) begin
        if (deb_cnt == DEB_LAST) begin
          deb_pressed <= ~sync2;
          deb_cnt     <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end

    assign pressed[i] = deb_pressed;

`ifdef KEY_AUTO_REPEAT_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic [PER_W-1:0]  per_cnt;
    logic              step_i;

    // A step is issued on the initial press and again whenever the active
    // hold or period counter reaches its last value.
    always_comb begin
      step_i = 1'b0;
      case (state)
        ST_IDLE:   step_i = deb_pressed;
        ST_HELD:   step_i = deb_pressed && !both_pressed && (hold_cnt == HOLD_LAST);
        ST_REPEAT: step_i = deb_pressed && !both_pressed && (per_cnt == PER_LAST);
        default:   step_i = 1'b0;
      endcase
    end

    assign step[i] = step_i;

    // Press FSM. A release returns to IDLE from any state and clears both
    // counters. While both buttons are held the counters keep their values.
    always_ff @(posedge clk) begin
      if (!rst_n || !deb_pressed) begin
        state    <= ST_IDLE;
        hold_cnt <= '0;
        per_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_HELD;
            hold_cnt <= '0;
          end
          ST_HELD: begin
            if (!both_pressed) begin
              if (hold_cnt == HOLD_LAST) begin
                state    <= ST_REPEAT;
                hold_cnt <= '0;
                per_cnt  <= '0;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (!both_pressed) begin
              if (per_cnt == PER_LAST) begin
                per_cnt <= '0;
              end else begin
                per_cnt <= per_cnt + PER_W'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
`else
    assign step[i] = (state == ST_IDLE) && deb_pressed;

    // Two-state press FSM. HELD only marks that this press has already stepped.
    always_ff @(posedge clk) begin
      if (!rst_n || !deb_pressed) begin
        state <= ST_IDLE;
      end else begin
        state <= ST_HELD;
      end
    end
`endif
  end

  // If UP and DOWN step in the same cycle they cancel. A single step always
  // moves mode by one, so mode_chg marks a real change of value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode     <= INIT_MODE;
      mode_chg <= 1'b0;
    end else begin
      mode_chg <= 1'b0;
      if (step[1] && !step[0]) begin
        mode     <= mode + 3'd1;
        mode_chg <= 1'b1;
      end else if (step[0] && !step[1]) begin
        mode     <= mode - 3'd1;
        mode_chg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_mode_sel.sv
// tb_key_mode_sel
//   Directed bench for key_mode_sel with short timing constants
//   (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8). Inputs change 1 ns
//   after a rising edge. Outputs are checked 1 ns after the edge on which they
//   are expected to settle. Expected values for the repeat sequence follow
//   the KEY_AUTO_REPEAT_EN macro.

module tb_key_mode_sel;

`ifdef KEY_AUTO_REPEAT_EN
  localparam bit AUTO_RPT = 1'b1;
`else
  localparam bit AUTO_RPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up_n;
  logic       btn_dn_n;
  logic [2:0] mode;
  logic       mode_chg;
  logic [1:0] btn_state;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_mode;

  key_mode_sel #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .INIT_MODE      (3'd0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up_n (btn_up_n),
    .btn_dn_n (btn_dn_n),
    .mode     (mode),
    .mode_chg (mode_chg),
    .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then step 1 ns past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive both button pins, then run the given number of cycles.
  task automatic applyStimulus(input logic up_n, input logic dn_n, input int cycles);
    btn_up_n = up_n;
    btn_dn_n = dn_n;
    tick(cycles);
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] em, input logic ec,
                             input logic [1:0] es);
    total++;
    assert (mode === em && mode_chg === ec && btn_state === es)
    else begin
      bad++;
      $error("[TB] FAIL %s: got mode=%0d chg=%b state=%b, expected mode=%0d chg=%b state=%b",
             tag, mode, mode_chg, btn_state, em, ec, es);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    tick(2);
    checkOutput("reset", 3'd0, 1'b0, 2'b00);
    rst_n = 1'b1;
    tick(1);

    // Clean UP press. Debounced at edge 6, mode steps at edge 7.
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("up_debounced", 3'd0, 1'b0, 2'b10);
    tick(1);
    checkOutput("up_step", 3'd1, 1'b1, 2'b10);
    tick(1);
    checkOutput("up_pulse_end", 3'd1, 1'b0, 2'b10);
    tick(2);
    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("up_release", 3'd1, 1'b0, 2'b00);
    tick(2);
    checkOutput("up_release_hold", 3'd1, 1'b0, 2'b00);

    // Bouncing UP pin with 3-cycle phases, never accepted.
    for (int p = 0; p < 5; p++) begin
      applyStimulus(1'b0, 1'b1, 3);
      checkOutput("bounce_low", 3'd1, 1'b0, 2'b00);
      applyStimulus(1'b1, 1'b1, 3);
      checkOutput("bounce_high", 3'd1, 1'b0, 2'b00);
    end
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("bounce_settled", 3'd1, 1'b0, 2'b10);
    tick(1);
    checkOutput("bounce_step", 3'd2, 1'b1, 2'b10);
    tick(1);
    checkOutput("bounce_pulse_end", 3'd2, 1'b0, 2'b10);
    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("bounce_release", 3'd2, 1'b0, 2'b00);

    // Reset to 0, DOWN wraps to 7, then eight UP presses wrap back to 7.
    rst_n = 1'b0;
    tick(1);
    checkOutput("reset_again", 3'd0, 1'b0, 2'b00);
    rst_n = 1'b1;
    tick(1);
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("dn_debounced", 3'd0, 1'b0, 2'b01);
    tick(1);
    checkOutput("dn_wrap", 3'd7, 1'b1, 2'b01);
    tick(1);
    checkOutput("dn_pulse_end", 3'd7, 1'b0, 2'b01);
    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("dn_release", 3'd7, 1'b0, 2'b00);

    exp_mode = 3'd7;
    for (int k = 0; k < 8; k++) begin
      exp_mode = exp_mode + 3'd1;
      applyStimulus(1'b0, 1'b1, 7);
      checkOutput("up_seq_step", exp_mode, 1'b1, 2'b10);
      tick(1);
      checkOutput("up_seq_pulse_end", exp_mode, 1'b0, 2'b10);
      applyStimulus(1'b1, 1'b1, 6);
      checkOutput("up_seq_release", exp_mode, 1'b0, 2'b00);
    end

    // UP held. With auto-repeat, steps land at edges 7, 27, 35, 43, 51, 59.
    applyStimulus(1'b0, 1'b1, 7);
    checkOutput("rpt_first", 3'd0, 1'b1, 2'b10);
    tick(1);
    checkOutput("rpt_first_end", 3'd0, 1'b0, 2'b10);
    tick(18);
    checkOutput("rpt_before_delay", 3'd0, 1'b0, 2'b10);
    tick(1);
    exp_mode = AUTO_RPT ? 3'd1 : 3'd0;
    checkOutput("rpt_delay_step", exp_mode, AUTO_RPT, 2'b10);
    tick(1);
    checkOutput("rpt_delay_end", exp_mode, 1'b0, 2'b10);
    tick(6);
    checkOutput("rpt_before_period", exp_mode, 1'b0, 2'b10);
    for (int k = 2; k <= 5; k++) begin
      tick((k == 2) ? 1 : 8);
      exp_mode = AUTO_RPT ? 3'(k) : 3'd0;
      checkOutput("rpt_period_step", exp_mode, AUTO_RPT, 2'b10);
    end

    // One-cycle reset mid-sequence with UP still held, then a fresh press.
    rst_n = 1'b0;
    tick(1);
    checkOutput("rst_mid_repeat", 3'd0, 1'b0, 2'b00);
    rst_n = 1'b1;
    tick(5);
    checkOutput("rst_refilter", 3'd0, 1'b0, 2'b00);
    tick(1);
    checkOutput("rst_redebounced", 3'd0, 1'b0, 2'b10);
    tick(1);
    checkOutput("rst_fresh_step", 3'd1, 1'b1, 2'b10);
    tick(1);
    checkOutput("rst_fresh_end", 3'd1, 1'b0, 2'b10);
    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("rst_release", 3'd1, 1'b0, 2'b00);

    // Both pressed in the same cycle: the steps cancel and nothing repeats.
    applyStimulus(1'b0, 1'b0, 6);
    checkOutput("both_debounced", 3'd1, 1'b0, 2'b11);
    tick(1);
    checkOutput("both_cancel", 3'd1, 1'b0, 2'b11);
    tick(20);
    checkOutput("both_no_repeat_a", 3'd1, 1'b0, 2'b11);
    tick(20);
    checkOutput("both_no_repeat_b", 3'd1, 1'b0, 2'b11);
    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("both_release", 3'd1, 1'b0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_mode_sel.md
# key_mode_sel

Push-button front end that produces the 3-bit output-select code feeding the DA output multiplexer's `key` input. It synchronises and debounces two asynchronous active-low buttons (UP/DOWN) and steps a wrap-around mode register, with optional hold-to-repeat. A one-cycle change strobe lets downstream logic blank or realign the DA path on each switch.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY`, default 25_000_000: cycles a button must stay debounced-pressed before the first auto-repeat step.
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent auto-repeat steps.
- `INIT_MODE`, default 3'd0: mode value loaded at reset.
- `clk` input 1: system clock (same clock as the filter/DA logic).
- `rst_n` input 1: reset rst_n, synchronous, active-low.
- `btn_up_n` input 1: UP button, asynchronous, active-low (0 = pressed).
- `btn_dn_n` input 1: DOWN button, asynchronous, active-low.
- `mode` output 3: current select code, registered.
- `mode_chg` output 1: one-cycle pulse, high in the first cycle `mode` shows a new value.
- `btn_state` output 2: debounced pressed flags {up, dn}, 1 = pressed.

## Operation
- Per button: 2-FF synchroniser (reset to 1 = released) -> debouncer -> press FSM.
- Debouncer: counter increments while synced sample differs from debounced level, clears to 0 when equal. When counter = DEBOUNCE_CYCLES-1 and sample still differs, debounced level takes the sample and counter clears. Any bounce restarts the count.
- Press FSM states: IDLE (released), HELD (pressed, counting REPEAT_DELAY), REPEAT (counting REPEAT_PERIOD). IDLE->HELD on debounced press, emits one step. HELD->REPEAT when hold counter reaches REPEAT_DELAY-1, emits one step. In REPEAT, emits a step each time the period counter reaches REPEAT_PERIOD-1, then reloads. Any state -> IDLE on debounced release; counters clear.
- Mode update: UP step -> mode+1 mod 8 (7 -> 0); DOWN step -> mode-1 mod 8 (0 -> 7).
- Simultaneous: UP and DOWN steps in the same cycle cancel; mode unchanged, no `mode_chg`. While both buttons are debounced-pressed, auto-repeat steps from both are suppressed and hold counters freeze.
- `mode_chg` asserts only when `mode` actually changes value.

## Timing
- Reset (synchronous, rst_n low at a clk edge): `mode` = INIT_MODE, `mode_chg` = 0, `btn_state` = 2'b00, synchronisers = 1, all counters 0, FSMs IDLE. Takes effect on the first edge with rst_n low, including mid-debounce or mid-repeat.
- A button held through reset release is treated as a fresh press: one step after full debounce.
- Press latency: pin low at edge 0 -> synced at edge 2 -> debounced level/`btn_state` set at edge 2+DEBOUNCE_CYCLES -> `mode` and `mode_chg` updated at edge 3+DEBOUNCE_CYCLES.
- First repeat: REPEAT_DELAY cycles after the debounced press; later repeats every REPEAT_PERIOD cycles.
- Release latency: 2+DEBOUNCE_CYCLES edges. Releases never step `mode`.
- `mode_chg` is exactly one cycle wide; back-to-back steps give back-to-back pulses only if steps fall on consecutive cycles.

## Configuration
- `KEY_AUTO_REPEAT_EN` defined: HELD/REPEAT behaviour as above.
- Not defined: FSM is IDLE/HELD only. Exactly one step per debounced press. REPEAT_DELAY/REPEAT_PERIOD are ignored and their counters are not built.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, INIT_MODE=0.
- Reset, then a clean UP press held 10 cycles: `mode` 0->1 at edge 7 after pin low, one `mode_chg` pulse, no change on release.
- UP pin toggling every 3 cycles for 30 cycles, then stable low: no step during bouncing; exactly one step 6 cycles after it stabilises.
- DOWN press from mode 0: `mode` = 7. Eight UP presses from 7: sequence 0..7, eight `mode_chg` pulses, wrap verified.
- With `KEY_AUTO_REPEAT_EN`, UP held 60 cycles after debounce: steps at +0, +20, +28, +36, +44, +52. Without the macro: a single step only.
- Both buttons pressed in the same cycle: steps cancel, `mode` unchanged, no `mode_chg`, no repeats while both are held.
- rst_n low for one cycle during a repeat sequence at mode 5: `mode` = 0 next cycle, `mode_chg` = 0. Button still held: one fresh step after 6 cycles.
